palette_lut: RTL and testbench
==============================

PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 4, meaning palette index width, with ENTRIES = 2**INDEX_W.
REQ-002 The block SHALL have parameter COLOR_W, default 4, meaning bits per colour channel.
REQ-003 The block SHALL have parameter INIT_COLOR, default 12'h18B, meaning the {R,G,B} value loaded into every entry at reset, 3*COLOR_W bits wide.
REQ-004 The block SHALL have parameter FADE_PERIOD, default 4, meaning clocks per fade step; legal range is 1 or more.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
REQ-006 The lookup and write ports SHALL be:
- pix_valid_in  in  1  index valid this cycle.
- pix_index  in  INDEX_W  palette index.
- pix_valid_out  out  1  colour valid.
- red, green, blue  out  COLOR_W each  looked-up colour.
- wr_en  in  1  palette write request.
- wr_addr  in  INDEX_W  entry to write.
- wr_data  in  3*COLOR_W  {R,G,B}.
- wr_ready  out  1  write accepted when high.
- init_busy  out  1  reset initialisation in progress.
REQ-007 The fade ports SHALL be:
- fade_start  in  1  begin fade.
- fade_dir  in  1  direction: 1 = fade out, 0 = fade in.
- fade_busy  out  1  fade in progress.

Function
REQ-008 Palette storage SHALL be ENTRIES words of 3*COLOR_W bits, held in registers or inferred RAM.
REQ-009 The controller SHALL have states INIT and RUN; Reset forces INIT with init counter 0.
REQ-010 In INIT, one entry SHALL be written per cycle: entry[cnt] <= INIT_COLOR, then cnt++.
REQ-011 The controller SHALL move INIT->RUN on the cycle after cnt = ENTRIES-1 is written, so INIT lasts exactly ENTRIES cycles.
REQ-012 init_busy SHALL be 1 exactly while in INIT.
REQ-013 wr_ready SHALL equal (state == RUN); wr_en while wr_ready is 0 SHALL be dropped and never queued.
REQ-014 A write SHALL commit at the rising edge where wr_en and wr_ready are both 1.
REQ-015 Lookup latency SHALL be exactly 2 cycles: pix_valid_out(t+2) = pix_valid_in(t), with the colour from entry[pix_index(t)].
REQ-016 Lookups SHALL be fully pipelined at one per cycle, with no stalls and no backpressure.
REQ-017 When a read and a write target the same address in the same cycle, the read SHALL return the old data; lookups issued from the next cycle on SHALL return the new data.
REQ-018 When pix_valid_out = 0, red, green and blue SHALL all be 0 (blanking).
REQ-019 A lookup issued during INIT SHALL produce pix_valid_out = 1 with colour 0.
REQ-020 The lookup pipeline SHALL keep running during INIT and RUN, so pix_valid_out remains pipelined during INIT.
REQ-021 The fade FSM SHALL have states IDLE and FADING, and a register atten of COLOR_W bits.
REQ-022 Each output channel SHALL equal sat(c - atten), saturating at 0, applied in the output stage; latency SHALL remain 2.
REQ-023 In IDLE, fade_start SHALL move the FSM to FADING, latch fade_dir and clear the step counter.
REQ-024 In FADING, atten SHALL step by 1 every FADE_PERIOD cycles: +1 when fade_dir = 1, -1 when fade_dir = 0.
REQ-025 The FSM SHALL return to IDLE on the step that reaches 2**COLOR_W-1 (fade out) or 0 (fade in).
REQ-026 fade_start while atten is already at the target SHALL cause a single-cycle FADING, then IDLE, with atten unchanged.
REQ-027 fade_start while in FADING SHALL be ignored.
REQ-028 atten SHALL hold its value in IDLE, so a faded-out screen stays dark.
REQ-029 fade_busy SHALL equal (state == FADING).
REQ-030 Palette writes and lookups SHALL be unaffected by the fade FSM state.

Reset
REQ-031 Reset SHALL set state INIT, cnt 0, clear both pipeline stages, and drive pix_valid_out 0 and red/green/blue 0 on the next edge.
REQ-032 Reset SHALL set init_busy 1, wr_ready 0, fade state IDLE, atten 0 and fade_busy 0.
REQ-033 Reset asserted during RUN, INIT or FADING SHALL abort the operation and restart INIT from entry 0.
REQ-034 After any reset, all prior palette writes SHALL be overwritten with INIT_COLOR.
REQ-035 Lookups in flight at reset SHALL be discarded.

Configuration
REQ-036 Macro PALETTE_LUT_FADE_EN SHALL compile the fade FSM and the attenuation logic in.
REQ-037 Without PALETTE_LUT_FADE_EN, the fade ports SHALL still exist; fade_start and fade_dir SHALL be ignored, fade_busy SHALL be tied to 0, and the output SHALL be the raw palette value.

Verification
REQ-038 Release Reset, count cycles with init_busy high -> exactly 16 (default params); lookups of all indices 0..15 -> colour 1,8,B.
REQ-039 Write addr 3 = 12'hF00, then back-to-back lookups of 3,3,5 -> 2-cycle latency, colours F00, F00, 18B, no bubbles.
REQ-040 Same cycle: write addr 7 = 12'h0F0 and look up index 7, then look up 7 on the next cycle -> 18B, then 0F0.
REQ-041 With fade enabled and FADE_PERIOD=4, fade_start with fade_dir=1 -> fade_busy high for 60 cycles, atten 15, entry 18B outputs 000; fade_dir=0 -> returns to 18B.
REQ-042 Reset mid-fade with atten=6 and a write pending -> atten 0, fade_busy 0, INIT reruns for 16 cycles, wr_ready low during INIT, write lost.
REQ-043 Lookup during INIT and wr_en during INIT -> pix_valid_out 1 with colour 000, and the entry unchanged after INIT.

Source files
------------

// File: rtl/palette_lut.sv
// palette_lut: palette lookup with reset-time initialisation and optional fade.
//
// Storage is ENTRIES words of {R,G,B}. After Reset the controller walks every
// entry writing INIT_COLOR (one per clock); palette writes are refused until
// that walk completes. Lookups are a fixed two-stage pipeline that never stalls.
//
// Optional feature macro: PALETTE_LUT_FADE_EN
//   defined   -> fade FSM plus per-channel saturating attenuation in the
//                output stage
//   undefined -> fade ports exist but are ignored; fade_busy is 0 and the
//                output is the raw palette value
//
// Controller states
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_INIT    | writing INIT_COLOR into entry cnt, writes refused
//   ST_RUN     | normal operation, palette writes accepted
//
// Fade states (PALETTE_LUT_FADE_EN only)
//   state      | meaning
//   -----------+---------------------------------------------------------
//   F_IDLE     | attenuation held, waiting for fade_start
//   F_FADING   | attenuation stepping toward 0 or full scale
module palette_lut #(
  parameter int                     INDEX_W     = 4,
  parameter int                     COLOR_W     = 4,
  parameter logic [3*COLOR_W-1:0]   INIT_COLOR  = 12'h18B,
  parameter int                     FADE_PERIOD = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   pix_valid_in,
  input  logic [INDEX_W-1:0]     pix_index,
  output logic                   pix_valid_out,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  input  logic                   wr_en,
  input  logic [INDEX_W-1:0]     wr_addr,
  input  logic [3*COLOR_W-1:0]   wr_data,
  output logic                   wr_ready,
  output logic                   init_busy,
  input  logic                   fade_start,
  input  logic                   fade_dir,
  output logic                   fade_busy
);

  localparam int ENTRIES = 2**INDEX_W;
  localparam int PIX_W   = 3*COLOR_W;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                 state;
  logic [INDEX_W-1:0]   cnt;
  logic [PIX_W-1:0]     mem [ENTRIES];

  logic                 s1_valid;
  logic [PIX_W-1:0]     s1_color;

  logic [COLOR_W-1:0]   raw_r;
  logic [COLOR_W-1:0]   raw_g;
  logic [COLOR_W-1:0]   raw_b;
  logic [COLOR_W-1:0]   adj_r;
  logic [COLOR_W-1:0]   adj_g;
  logic [COLOR_W-1:0]   adj_b;

  assign init_busy = (state == ST_INIT);
  assign wr_ready  = (state == ST_RUN);

  // Init controller: walk cnt over every entry once, then enter RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + INDEX_W'(1);
      if (cnt == INDEX_W'(ENTRIES-1)) begin
        state <= ST_RUN;
      end
    end
  end

  // Palette storage: init walk has priority; user writes only land in RUN,
  // anything presented earlier is simply dropped.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == ST_INIT) begin
        mem[cnt] <= INIT_COLOR;
      end else if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Lookup stage 1: read the entry (old data on a same-cycle write); lookups
  // issued during INIT carry black because the palette is not yet valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_color <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      s1_color <= (state == ST_RUN) ? mem[pix_index] : '0;
    end
  end

  assign raw_r = s1_color[3*COLOR_W-1:2*COLOR_W];
  assign raw_g = s1_color[2*COLOR_W-1:COLOR_W];
  assign raw_b = s1_color[COLOR_W-1:0];

`ifdef PALETTE_LUT_FADE_EN

  localparam logic F_IDLE   = 1'b0;
  localparam logic F_FADING = 1'b1;

  localparam int                 TICK_W    = (FADE_PERIOD > 1) ? $clog2(FADE_PERIOD) : 1;
  localparam logic [COLOR_W-1:0] ATTEN_MAX = '1;

  logic                 fstate;
  logic                 fdir;
  logic [TICK_W-1:0]    tick;
  logic [COLOR_W-1:0]   atten;
  logic [COLOR_W-1:0]   atten_target;
  logic [COLOR_W-1:0]   atten_step;

  assign atten_target = fdir ? ATTEN_MAX : '0;
  assign atten_step   = fdir ? (atten + COLOR_W'(1)) : (atten - COLOR_W'(1));
  assign fade_busy    = (fstate == F_FADING);

  // Fade FSM: atten moves one step every FADE_PERIOD clocks and the FSM
  // leaves FADING on the step that lands on the target. Starting a fade that
  // is already at its target costs one FADING cycle and changes nothing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fstate <= F_IDLE;
      fdir   <= 1'b0;
      tick   <= '0;
      atten  <= '0;
    end else if (fstate == F_IDLE) begin
      if (fade_start) begin
        fstate <= F_FADING;
        fdir   <= fade_dir;
        tick   <= '0;
      end
    end else begin
      if (atten == atten_target) begin
        fstate <= F_IDLE;
      end else if (tick == TICK_W'(FADE_PERIOD-1)) begin
        tick  <= '0;
        atten <= atten_step;
        if (atten_step == atten_target) begin
          fstate <= F_IDLE;
        end
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

  assign adj_r = (raw_r >= atten) ? (raw_r - atten) : '0;
  assign adj_g = (raw_g >= atten) ? (raw_g - atten) : '0;
  assign adj_b = (raw_b >= atten) ? (raw_b - atten) : '0;

`else

  localparam int unused_fade_period = FADE_PERIOD;

  logic unused_fade_in;

  assign unused_fade_in = fade_start ^ fade_dir;
  assign fade_busy      = 1'b0;

  assign adj_r = raw_r;
  assign adj_g = raw_g;
  assign adj_b = raw_b;

`endif

  // Lookup stage 2: registered outputs, colour forced to black when not valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_valid_out <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      red           <= s1_valid ? adj_r : '0;
      green         <= s1_valid ? adj_g : '0;
      blue          <= s1_valid ? adj_b : '0;
    end
  end

endmodule

// File: tb/tb_palette_lut.sv
// Bench for palette_lut at default parameters. A behavioural model tracks the
// palette contents, remaining init cycles, the expected output pixel and the
// fade attenuation; a negedge process compares every output each cycle.
// Directed sections also pin hand-computed values. Honours PALETTE_LUT_FADE_EN.
module tb_palette_lut;

  localparam int FADE_PERIOD = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid_in = 1'b0;
  logic [3:0]  pix_index = '0;
  logic        pix_valid_out;
  logic [3:0]  red, green, blue;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready;
  logic        init_busy;
  logic        fade_start = 1'b0;
  logic        fade_dir = 1'b0;
  logic        fade_busy;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  palette_lut dut (
    .Clk(Clk), .Reset(Reset),
    .pix_valid_in(pix_valid_in), .pix_index(pix_index),
    .pix_valid_out(pix_valid_out), .red(red), .green(green), .blue(blue),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .init_busy(init_busy),
    .fade_start(fade_start), .fade_dir(fade_dir), .fade_busy(fade_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [3:0] satsub(input logic [3:0] c, input int a);
    if (int'(c) >= a) return 4'(int'(c) - a);
    return 4'h0;
  endfunction

  // ---------------- behavioural model ----------------
  logic [11:0] pal [16];
  int          init_left = 0;
  logic        m1_v = 1'b0;
  logic [11:0] m1_c = '0;
  logic        e_v = 1'b0;
  logic [11:0] e_c = '0;
  int          m_atten = 0;
  bit          m_fbusy = 1'b0;
  bit          m_fdir = 1'b0;
  int          m_ftick = 0;
  bit          started = 1'b0;

  // Advance the model by one clock from the inputs seen at this edge.
  always @(posedge Clk) begin
    int tgt;
    if (Reset) begin
      for (int i = 0; i < 16; i++) pal[i] = 12'h18B;
      init_left = 16;
      m1_v = 1'b0; m1_c = '0; e_v = 1'b0; e_c = '0;
      m_fbusy = 1'b0; m_atten = 0; m_ftick = 0;
    end else begin
      e_v = m1_v;
      e_c = m1_v ? {satsub(m1_c[11:8], m_atten), satsub(m1_c[7:4], m_atten),
                    satsub(m1_c[3:0], m_atten)} : 12'h000;
      m1_v = pix_valid_in;
      m1_c = (init_left > 0) ? 12'h000 : pal[pix_index];
      if (wr_en && init_left == 0) pal[wr_addr] = wr_data;
      if (init_left > 0) init_left--;
`ifdef PALETTE_LUT_FADE_EN
      if (!m_fbusy) begin
        if (fade_start) begin
          m_fbusy = 1'b1; m_fdir = fade_dir; m_ftick = 0;
        end
      end else begin
        tgt = m_fdir ? 15 : 0;
        if (m_atten == tgt) m_fbusy = 1'b0;
        else begin
          m_ftick++;
          if (m_ftick == FADE_PERIOD) begin
            m_ftick = 0;
            m_atten += m_fdir ? 1 : -1;
            if (m_atten == tgt) m_fbusy = 1'b0;
          end
        end
      end
`endif
    end
    started = 1'b1;
  end

  // Compare every output against the model on every cycle.
  always @(negedge Clk) begin
    if (started) begin
      chk("m_valid", pix_valid_out, e_v);
      chk("m_color", {red, green, blue}, e_c);
      chk("m_init_busy", init_busy, (init_left > 0) ? 1 : 0);
      chk("m_wr_ready", wr_ready, (init_left == 0) ? 1 : 0);
      chk("m_fade_busy", fade_busy, m_fbusy ? 1 : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0]  lk_idx [$];
  logic [11:0] lk_exp [$];

  task automatic add(input logic [3:0] idx, input logic [11:0] exp);
    lk_idx.push_back(idx);
    lk_exp.push_back(exp);
  endtask

  // Issue queued lookups back to back; each result must appear two clocks later.
  task automatic run_lookups(input string name);
    int n = lk_idx.size();
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        pix_valid_in = 1'b1;
        pix_index    = lk_idx[j];
      end else begin
        pix_valid_in = 1'b0;
      end
      tick();
      if (j >= 1) begin
        chk({name, "_valid"}, pix_valid_out, 1);
        chk(name, {red, green, blue}, lk_exp[j-1]);
      end
    end
    lk_idx.delete();
    lk_exp.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", pix_valid_out, 0);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    Reset = 1'b0;

    n = 0;
    while (init_busy && n < 100) begin
      n++;
      tick();
    end
    chk("init_cycles", n, 16);

    for (int i = 0; i < 16; i++) add(4'(i), 12'h18B);
    run_lookups("init_color");

    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'hF00;
    tick();
    wr_en = 1'b0;
    add(4'd3, 12'hF00); add(4'd3, 12'hF00); add(4'd5, 12'h18B);
    run_lookups("wr_then_rd");

    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 12'h0F0;
    pix_valid_in = 1'b1; pix_index = 4'd7;
    tick();
    wr_en = 1'b0;
    tick();
    chk("same_cycle_old", {red, green, blue}, 12'h18B);
    pix_valid_in = 1'b0;
    tick();
    chk("next_cycle_new", {red, green, blue}, 12'h0F0);
    tick();
    chk("blank_valid", pix_valid_out, 0);
    chk("blank_rgb", {red, green, blue}, 12'h000);

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 12'h123;
    tick();
    wr_addr = 4'd15; wr_data = 12'hFFF;
    tick();
    wr_en = 1'b0;
    add(4'd0, 12'h123); add(4'd15, 12'hFFF); add(4'd7, 12'h0F0); add(4'd3, 12'hF00);
    run_lookups("multi_wr");

`ifdef PALETTE_LUT_FADE_EN
    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    n = 0;
    while (fade_busy && n < 500) begin
      n++;
      tick();
    end
    chk("fade_out_cycles", n, 60);
    add(4'd2, 12'h000); add(4'd15, 12'h000);
    run_lookups("faded_out");

    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    chk("at_target_busy", fade_busy, 1);
    tick();
    chk("at_target_idle", fade_busy, 0);

    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    n = 0;
    while (fade_busy && n < 500) begin
      n++;
      tick();
    end
    chk("fade_in_cycles", n, 60);
    add(4'd2, 12'h18B); add(4'd3, 12'hF00);
    run_lookups("faded_in");

    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    repeat (24) tick();
    add(4'd2, 12'h025);
    run_lookups("mid_fade_atten6");
`else
    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    repeat (8) tick();
    chk("fade_busy_tied", fade_busy, 0);
    add(4'd2, 12'h18B); add(4'd0, 12'h123);
    run_lookups("no_fade_raw");
`endif

    Reset = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 12'hABC;
    pix_valid_in = 1'b1; pix_index = 4'd5;
    tick();
    Reset = 1'b0;
    chk("rerst_valid", pix_valid_out, 0);
    chk("rerst_fade_busy", fade_busy, 0);
    n = 0;
    while (init_busy && n < 100) begin
      chk("wr_ready_init", wr_ready, 0);
      tick();
      n++;
      if (n == 4) begin
        chk("init_lookup_valid", pix_valid_out, 1);
        chk("init_lookup_color", {red, green, blue}, 12'h000);
      end
    end
    wr_en = 1'b0;
    pix_valid_in = 1'b0;
    chk("reinit_cycles", n, 16);
    add(4'd5, 12'h18B); add(4'd3, 12'h18B); add(4'd7, 12'h18B); add(4'd0, 12'h18B);
    add(4'd15, 12'h18B);
    run_lookups("after_reset");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
